fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch front end feeding the IF/ID pipeline register. Issues sequential
//  PC requests to a variable-latency instruction memory, buffers returned words with
//  their PC/PC+4 in a DEPTH-entry FIFO, and presents them to decode on a valid/ready
//  handshake. A redirect from the MEM stage (taken branch, JALR) flushes the queue and
//  discards stale in-flight responses.
// PARAMETERS
//  PC_W       9   program counter width (byte address)
//  INS_W      32  instruction width
//  DEPTH      4   FIFO entries, power of 2, >=2
//  MAX_OUTST  2   max outstanding imem requests, 1..DEPTH
// PORTS
//  clk           in   1      global clock, rising edge
//  reset         in   1      asynchronous, active-low reset
//  imem_req      out  1      fetch request valid
//  imem_addr     out  PC_W   fetch address (word aligned, [1:0]=0)
//  imem_gnt      in   1      request accepted this cycle when imem_req=1
//  imem_rvalid   in   1      response valid; responses return in request order
//  imem_rdata    in   INS_W  response instruction word
//  redirect_valid in  1      flush and restart fetch at redirect_pc
//  redirect_pc   in   PC_W   new fetch PC (bit 0 cleared internally)
//  out_valid     out  1      out_* hold a valid instruction
//  out_ready     in   1      decode accepts (driven as !hazard by the stall logic)
//  out_pc        out  PC_W   PC of out_instr
//  out_pc_plus4  out  PC_W   out_pc + 4, modulo 2**PC_W
//  out_instr     out  INS_W  instruction word
// BEHAVIOUR
//  Reset (reset=0, async): fetch_pc=0, resp_pc=0, FIFO count=0, outst=0, drop_cnt=0;
//   imem_req=0, out_valid=0, out_pc=0, out_pc_plus4=0, out_instr=0.
//  State: fetch_pc (next to request), resp_pc (PC of next live response), outst
//   (all in-flight requests), drop_cnt (stale in-flight to discard), FIFO count.
//  imem_req = !redirect_valid && outst<MAX_OUTST && (count+outst-drop_cnt)<DEPTH;
//   imem_addr=fetch_pc. On req&gnt: fetch_pc+=4 (wraps mod 2**PC_W), outst+1.
//  Credit rule: live slots reserved at issue, so a live response is never dropped for
//   lack of space; FIFO overflow is impossible by construction (assert it).
//  Response (rvalid): outst-1. If drop_cnt>0: discard, drop_cnt-1. Else push
//   {resp_pc, resp_pc+4, rdata}, resp_pc+=4. Push latency: visible at out_* the
//   cycle after rvalid (see FETCHQ_BYPASS_EN).
//  Output: out_* = FIFO head; pop on out_valid&&out_ready. Push+pop same cycle with
//   count=DEPTH or 0 is legal; count unchanged. out_* stable while out_valid&&!out_ready.
//  Redirect (highest priority): next cycle count=0, out_valid=0; fetch_pc=resp_pc=
//   redirect_pc&~1; drop_cnt = outst - (rvalid?1:0) (grant impossible, req=0).
//   Response and pop in the redirect cycle are ignored. Back-to-back redirects: each
//   reloads PCs; drop_cnt recomputed from current outst. New requests may issue the
//   cycle after redirect while drop_cnt>0.
//  Reset mid-operation: all state cleared immediately; responses to pre-reset requests
//   are the memory's responsibility to squash (memory shares reset).
// CONFIGURATION
//  FETCHQ_BYPASS_EN defined: when FIFO empty and a live response arrives, out_valid=1
//   combinationally that cycle with the response data; if out_ready, not pushed
//   (zero-cycle latency). Otherwise pushed as normal.
//  Undefined: out_* driven only from FIFO registers; min imem_rvalid->out_valid = 1 cycle.
// TESTING
//  Reset, gnt=1, 1-cycle imem latency, ready=1 -> out_pc 0,4,8,... one per cycle after
//   fill; out_pc_plus4=out_pc+4; imem_req never exceeds 2 outstanding.
//  ready=0 for 10 cycles -> exactly DEPTH=4 entries buffered, imem_req drops to 0,
//   out_* held at pc=0; ready=1 -> pc 0,4,8,12,16 in order, no gaps/duplicates.
//  Redirect to 0x40 with 2 outstanding, rvalid=0 -> next 2 responses discarded,
//   first out_pc=0x40; redirect_pc=0x41 -> out_pc=0x40.
//  Redirect in same cycle as rvalid and pop, outst=2 -> drop_cnt=1, out_valid=0 next
//   cycle, following live response tagged redirect_pc.
//  fetch_pc=0x1FC, sequential -> next out_pc=0x000, out_pc_plus4 of 0x1FC is 0x000.
//  Assert reset while FIFO full and 2 outstanding -> all outputs 0 same cycle; after
//   release first request addr=0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential PC requests, buffers responses in a DEPTH-entry FIFO.
// Optional macro FETCHQ_BYPASS_EN forwards a live response straight to out_* when the queue is empty.
module fetch_queue #(
    parameter int PC_W      = 9,
    parameter int INS_W     = 32,
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [PC_W-1:0]  out_pc_plus4,
    output logic [INS_W-1:0] out_instr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  resp_pc;
    logic [CW-1:0]    count;
    logic [OW-1:0]    outst;
    logic [OW-1:0]    drop_cnt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic [PC_W-1:0]  pc4_mem [DEPTH];
    logic [INS_W-1:0] ins_mem [DEPTH];

    logic fifo_empty;
    logic credit_ok;
    logic grant;
    logic live;
    logic bypass;
    logic pop;
    logic fifo_push;
    logic fifo_pop;

    always_comb begin
        fifo_empty = (count == '0);
        // Slots are reserved at issue: live in-flight requests count against FIFO space.
        credit_ok  = (int'(outst) < MAX_OUTST) &&
                     ((int'(count) + int'(outst) - int'(drop_cnt)) < DEPTH);
        imem_req   = reset && !redirect_valid && credit_ok;
        grant      = imem_req && imem_gnt;
        live       = reset && imem_rvalid && (drop_cnt == '0) && !redirect_valid;
`ifdef FETCHQ_BYPASS_EN
        bypass     = live && fifo_empty;
`else
        bypass     = 1'b0;
`endif
        out_valid  = reset && (!fifo_empty || bypass);
        if (bypass) begin
            out_pc       = resp_pc;
            out_pc_plus4 = resp_pc + PC_STEP;
            out_instr    = imem_rdata;
        end else begin
            out_pc       = pc_mem[rd_ptr];
            out_pc_plus4 = pc4_mem[rd_ptr];
            out_instr    = ins_mem[rd_ptr];
        end
        pop       = out_valid && out_ready && !redirect_valid;
        fifo_pop  = pop && !fifo_empty;
        fifo_push = live && !(bypass && out_ready);
    end

    assign imem_addr = fetch_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= '0;
            resp_pc  <= '0;
            count    <= '0;
            outst    <= '0;
            drop_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]  <= '0;
                pc4_mem[i] <= '0;
                ins_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Every request still in flight after this cycle is stale.
            fetch_pc <= redirect_pc & ~PC_W'(1);
            resp_pc  <= redirect_pc & ~PC_W'(1);
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            outst    <= outst - OW'(imem_rvalid);
            drop_cnt <= outst - OW'(imem_rvalid);
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            outst <= outst + OW'(grant) - OW'(imem_rvalid);
            if (imem_rvalid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - OW'(1);
            end
            if (live) begin
                resp_pc <= resp_pc + PC_STEP;
            end
            if (fifo_push) begin
                pc_mem[wr_ptr]  <= resp_pc;
                pc4_mem[wr_ptr] <= resp_pc + PC_STEP;
                ins_mem[wr_ptr] <= imem_rdata;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (!reset)
        !(fifo_push && !fifo_pop && (int'(count) == DEPTH)));

    orphan_resp_a: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rvalid && (outst == '0)));

endmodule
